csr_trap_ctrl: RTL and testbench



---
 rtl/csr_pkg.sv | 45 ++++
 rtl/csr_irq_pending.sv | 53 +++++
 rtl/csr_trap_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, cause codes, funct3 op encodings and trap FSM states.
// Pure definitions: no latency or backpressure of its own.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
  localparam logic [4:0] LOCAL_IRQ_BASE  = 5'd16;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_e;

  function automatic logic [31:0] csr_wdata(input logic [1:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src);
    case (op)
      OP_RS:   return old_val | src;
      OP_RC:   return old_val & ~src;
      default: return src;
    endcase
  endfunction

endpackage

// File: rtl/csr_irq_pending.sv
// Local interrupt front end: 2-flop sync, then level pass-through or edge latch per line.
// irq_in visible on mip after 2 edges; no backpressure, edge pendings hold until cleared.
module csr_irq_pending #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [15:0] IRQ_EDGE = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               clr_vld,
  input  logic [NUM_IRQ-1:0] clr_dat,
  output logic [NUM_IRQ-1:0] mip
);

  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;
  logic [NUM_IRQ-1:0] prev_q,  prev_d;
  logic [NUM_IRQ-1:0] pend_q,  pend_d;
  logic [NUM_IRQ-1:0] rise;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
    pend_d  = '0;
    mip     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (IRQ_EDGE[i]) begin
        // The rising edge is shown immediately so edge lines match level latency.
        mip[i]    = pend_q[i] | rise[i];
        pend_d[i] = rise[i] | (pend_q[i] & ~(clr_vld & ~clr_dat[i]));
      end else begin
        mip[i]    = sync2_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt/exception arbitration, registered redirect at T+1.
// Reads are combinational, writes land next edge; no backpressure. CSR_COUNTERS_EN adds mcycle/minstret.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          NUM_IRQ     = 4,
  parameter logic [15:0] IRQ_EDGE    = 16'h0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_we_ex,
  input  logic [11:0]        csr_ofs_ex,
  input  logic [2:0]         csr_op2_ex,
  input  logic [4:0]         csr_uimm_ex,
  input  logic [XLEN-1:0]    rs1_sel,
  output logic [XLEN-1:0]    csr_rd_data,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               take_ok,
  input  logic               exc_req_ex,
  input  logic [4:0]         exc_cause_ex,
  input  logic [XLEN-1:0]    exc_tval_ex,
  input  logic [29:0]        pc_excep,
  input  logic               cmd_mret_ex,
  input  logic               retire_ex,
  output logic               redirect,
  output logic [29:0]        redirect_pc,
  output logic               irq_pending
);

  trap_state_e        state_q, state_d;
  logic               st_mie_q, st_mie_d;
  logic               st_mpie_q, st_mpie_d;
  logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [29:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtval_q, mtval_d;
  logic               redirect_q, redirect_d;
  logic [29:0]        redirect_pc_q, redirect_pc_d;

  logic [NUM_IRQ-1:0] mip;
  logic [31:0]        mstatus_rd, mie_rd, mip_rd, csr_old, src, wdata;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [4:0]         irq_idx, trap_code;
  logic               in_run, exc_take, irq_take, trap_take, mret_take, wr_take, mip_clr_vld;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  csr_irq_pending #(
    .NUM_IRQ  (NUM_IRQ),
    .IRQ_EDGE (IRQ_EDGE)
  ) u_irq_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .clr_vld (mip_clr_vld),
    .clr_dat (wdata[LOCAL_IRQ_BASE +: NUM_IRQ]),
    .mip     (mip)
  );

  // MPP is hardwired to machine mode.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};

  always_comb begin
    mie_rd = '0;
    mip_rd = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      mie_rd[16+i] = mie_en_q[i];
      mip_rd[16+i] = mip[i];
    end
    csr_old = '0;
    case (csr_ofs_ex)
      CSR_MSTATUS: csr_old = mstatus_rd;
      CSR_MIE:     csr_old = mie_rd;
      CSR_MIP:     csr_old = mip_rd;
      CSR_MTVEC:   csr_old = mtvec_q;
      CSR_MEPC:    csr_old = {mepc_q, 2'b00};
      CSR_MCAUSE:  csr_old = mcause_q;
      CSR_MTVAL:   csr_old = mtval_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    csr_old = mcycle_q[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   csr_old = mcycle_q[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  csr_old = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: csr_old = minstret_q[63:32];
`endif
      default:     csr_old = '0;
    endcase
  end

  assign csr_rd_data = csr_old;

  always_comb begin
    in_run   = (state_q == ST_RUN);
    src      = csr_op2_ex[2] ? {27'b0, csr_uimm_ex} : rs1_sel;
    wdata    = csr_wdata(csr_op2_ex[1:0], csr_old, src);
    irq_mask = mie_en_q & mip;
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_mask[i]) irq_idx = 5'(i);
    end
    exc_take    = in_run & exc_req_ex;
    irq_take    = in_run & st_mie_q & (|irq_mask) & take_ok & ~exc_req_ex;
    trap_take   = exc_take | irq_take;
    mret_take   = in_run & cmd_mret_ex & ~trap_take;
    wr_take     = in_run & csr_we_ex & (csr_op2_ex[1:0] != 2'b00) & ~trap_take & ~mret_take;
    mip_clr_vld = wr_take & (csr_ofs_ex == CSR_MIP);
    trap_code   = exc_take ? exc_cause_ex : LOCAL_IRQ_BASE + irq_idx;
  end

  assign irq_pending = |irq_mask;

  always_comb begin
    state_d       = ST_RUN;
    st_mie_d      = st_mie_q;
    st_mpie_d     = st_mpie_q;
    mie_en_d      = mie_en_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (wr_take) begin
      case (csr_ofs_ex)
        CSR_MSTATUS: begin
          st_mie_d  = wdata[3];
          st_mpie_d = wdata[7];
        end
        CSR_MIE:    mie_en_d = wdata[LOCAL_IRQ_BASE +: NUM_IRQ];
        CSR_MTVEC:  mtvec_d  = {wdata[31:2], wdata[1] ? 2'b00 : wdata[1:0]};
        CSR_MEPC:   mepc_d   = wdata[31:2];
        CSR_MCAUSE: mcause_d = wdata;
        CSR_MTVAL:  mtval_d  = wdata;
        default: ;
      endcase
    end

    if (trap_take) begin
      state_d    = ST_ENTER;
      mepc_d     = pc_excep;
      mcause_d   = {irq_take, 26'b0, trap_code};
      mtval_d    = exc_take ? exc_tval_ex : 32'b0;
      st_mpie_d  = st_mie_q;
      st_mie_d   = 1'b0;
      redirect_d = 1'b1;
      // Only interrupts use the vector table; exceptions always go to the base.
      redirect_pc_d = (irq_take && mtvec_q[1:0] == 2'b01) ?
                      mtvec_q[31:2] + {25'b0, trap_code} : mtvec_q[31:2];
    end else if (mret_take) begin
      state_d       = ST_RETURN;
      st_mie_d      = st_mpie_q;
      st_mpie_d     = 1'b1;
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      mie_en_q      <= '0;
      mtvec_q       <= MTVEC_RESET;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      mie_en_q      <= mie_en_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

`ifdef CSR_COUNTERS_EN
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, retire_ex};
    // A written half is replaced outright; the counter skips its increment that cycle.
    if (wr_take) begin
      case (csr_ofs_ex)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        CSR_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        CSR_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_ex;
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed + randomized bench for csr_trap_ctrl; CSR read-back checked against a value model.
module tb_csr_trap_ctrl;
  import csr_pkg::*;

  logic        clk, rst_n, csr_we_ex;
  logic [11:0] csr_ofs_ex;
  logic [2:0]  csr_op2_ex;
  logic [4:0]  csr_uimm_ex;
  logic [31:0] rs1_sel, csr_rd_data;
  logic [3:0]  irq_in;
  logic        take_ok, exc_req_ex;
  logic [4:0]  exc_cause_ex;
  logic [31:0] exc_tval_ex;
  logic [29:0] pc_excep;
  logic        cmd_mret_ex, retire_ex, redirect;
  logic [29:0] redirect_pc;
  logic        irq_pending;

  int tests = 0;
  int fails = 0;

  csr_trap_ctrl #(
    .XLEN        (32),
    .NUM_IRQ     (4),
    .IRQ_EDGE    (16'h0007),
    .MTVEC_RESET (32'h0000_0100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_we_ex    (csr_we_ex),
    .csr_ofs_ex   (csr_ofs_ex),
    .csr_op2_ex   (csr_op2_ex),
    .csr_uimm_ex  (csr_uimm_ex),
    .rs1_sel      (rs1_sel),
    .csr_rd_data  (csr_rd_data),
    .irq_in       (irq_in),
    .take_ok      (take_ok),
    .exc_req_ex   (exc_req_ex),
    .exc_cause_ex (exc_cause_ex),
    .exc_tval_ex  (exc_tval_ex),
    .pc_excep     (pc_excep),
    .cmd_mret_ex  (cmd_mret_ex),
    .retire_ex    (retire_ex),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .irq_pending  (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_we_ex  = 1'b0;
    csr_ofs_ex = a;
    #1;
    v = csr_rd_data;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_ofs_ex  = a;
    csr_op2_ex  = op;
    csr_uimm_ex = d[4:0];
    rs1_sel     = d;
    csr_we_ex   = 1'b1;
    step();
    csr_we_ex   = 1'b0;
  endtask

  task automatic mret();
    cmd_mret_ex = 1'b1;
    step();
    cmd_mret_ex = 1'b0;
  endtask

  task automatic wait_redirect(input string tag, input int max_cycles);
    int n = 0;
    while (redirect !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, redirect, 1'b1);
  endtask

  function automatic logic [31:0] apply(input logic [1:0] op, input logic [31:0] old_v,
                                        input logic [31:0] s);
    if (op == 2'b01) return s;
    if (op == 2'b10) return old_v | s;
    return old_v & ~s;
  endfunction

  // Legal read-back value of each modelled register after a write of w.
  function automatic logic [31:0] legal(input int k, input logic [31:0] w);
    case (k)
      0:       return (w & 32'h0000_0088) | 32'h0000_1800;
      1:       return w & 32'h000F_0000;
      2:       return w[1] ? (w & 32'hFFFF_FFFC) : w;
      3:       return w & 32'hFFFF_FFFC;
      4, 5:    return w;
      default: return 32'h0;
    endcase
  endfunction

  logic [11:0] raddr [8];
  logic [31:0] mdl   [8];

  initial begin
    logic [29:0] pc3, pc4, pc4b, pc5, pc6, pc7;
    logic [31:0] t6;

    raddr = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, 12'h340};
    rst_n = 1'b0; csr_we_ex = 1'b0; csr_ofs_ex = '0; csr_op2_ex = '0; csr_uimm_ex = '0;
    rs1_sel = '0; irq_in = '0; take_ok = 1'b0; exc_req_ex = 1'b0; exc_cause_ex = '0;
    exc_tval_ex = '0; pc_excep = '0; cmd_mret_ex = 1'b0; retire_ex = 1'b0;

    // Reset values
    step(); step();
    check("rst redirect", redirect, 1'b0);
    check("rst redirect_pc", redirect_pc, 30'h0);
    rst_n = 1'b1;
    step();
    check("redirect after rst", redirect, 1'b0);
    check("irq_pending after rst", irq_pending, 1'b0);
    chk_csr("rst mtvec", CSR_MTVEC, 32'h0000_0100);
    chk_csr("rst mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("rst mie", CSR_MIE, 32'h0);
    chk_csr("rst mip", CSR_MIP, 32'h0);
    chk_csr("rst mepc", CSR_MEPC, 32'h0);
    chk_csr("rst mcause", CSR_MCAUSE, 32'h0);
    chk_csr("rst mtval", CSR_MTVAL, 32'h0);

    // Level line 3: two-edge synchroniser latency in both directions
    wr(CSR_MIE, 3'b001, 32'h0008_0000);
    irq_in[3] = 1'b1;
    step();
    chk_csr("lvl mip 1 edge", CSR_MIP, 32'h0);
    check("lvl pending 1 edge", irq_pending, 1'b0);
    step();
    chk_csr("lvl mip 2 edges", CSR_MIP, 32'h0008_0000);
    check("lvl pending 2 edges", irq_pending, 1'b1);
    check("lvl no trap with MIE=0", redirect, 1'b0);
    irq_in[3] = 1'b0;
    step();
    chk_csr("lvl fall 1 edge", CSR_MIP, 32'h0008_0000);
    step();
    chk_csr("lvl fall 2 edges", CSR_MIP, 32'h0);
    wr(CSR_MIE, 3'b001, 32'h0);

    // Edge line 0, vectored mtvec
    wr(CSR_MTVEC, 3'b001, 32'h0000_0201);
    wr(CSR_MSTATUS, 3'b110, 32'h8);
    wr(CSR_MIE, 3'b001, 32'h0001_0000);
    take_ok = 1'b1;
    pc3 = 30'($urandom);
    pc_excep = pc3;
    irq_in[0] = 1'b1;
    step();
    check("edge no redirect +1", redirect, 1'b0);
    step();
    check("edge no redirect +2", redirect, 1'b0);
    chk_csr("edge mip visible", CSR_MIP, 32'h0001_0000);
    step();
    check("edge redirect +3", redirect, 1'b1);
    check("edge vector pc", redirect_pc, 30'h90);
    irq_in[0] = 1'b0;
    chk_csr("irq16 mcause", CSR_MCAUSE, 32'h8000_0010);
    chk_csr("irq16 mepc", CSR_MEPC, {pc3, 2'b00});
    chk_csr("irq16 mtval", CSR_MTVAL, 32'h0);
    chk_csr("irq16 mstatus", CSR_MSTATUS, 32'h0000_1880);
    check("irq16 still pending", irq_pending, 1'b1);
    step();
    check("redirect one cycle", redirect, 1'b0);
    wr(CSR_MIP, 3'b011, 32'h0001_0000);
    chk_csr("mip16 cleared", CSR_MIP, 32'h0);
    check("pending cleared", irq_pending, 1'b0);
    mret();
    check("mret redirect", redirect, 1'b1);
    check("mret pc", redirect_pc, pc3);
    step();
    chk_csr("mret mstatus", CSR_MSTATUS, 32'h0000_1888);

    // Lines 1 and 2 together: lowest index first
    wr(CSR_MIE, 3'b001, 32'h0007_0000);
    pc4 = 30'($urandom);
    pc_excep = pc4;
    irq_in[2:1] = 2'b11;
    wait_redirect("irq17 redirect", 6);
    check("irq17 pc", redirect_pc, 30'h91);
    chk_csr("irq17 mcause", CSR_MCAUSE, 32'h8000_0011);
    chk_csr("irq17 mepc", CSR_MEPC, {pc4, 2'b00});
    irq_in[2:1] = 2'b00;
    step();
    chk_csr("both pending", CSR_MIP, 32'h0006_0000);
    wr(CSR_MIP, 3'b011, 32'h0002_0000);
    chk_csr("mip17 cleared", CSR_MIP, 32'h0004_0000);
    pc4b = 30'($urandom);
    pc_excep = pc4b;
    mret();
    check("mret17 redirect", redirect, 1'b1);
    check("mret17 pc", redirect_pc, pc4);
    step();
    wait_redirect("irq18 redirect", 4);
    check("irq18 pc", redirect_pc, 30'h92);
    chk_csr("irq18 mcause", CSR_MCAUSE, 32'h8000_0012);
    chk_csr("irq18 mepc", CSR_MEPC, {pc4b, 2'b00});

    // Exception beats a pending interrupt in the same cycle
    take_ok = 1'b0;
    step();
    mret();
    check("mret18 redirect", redirect, 1'b1);
    step();
    check("pending before exc", irq_pending, 1'b1);
    check("no trap without take_ok", redirect, 1'b0);
    pc5 = 30'($urandom);
    pc_excep = pc5;
    exc_req_ex = 1'b1; exc_cause_ex = CAUSE_ILLEGAL; exc_tval_ex = 32'hDEAD_BEEF; take_ok = 1'b1;
    step();
    exc_req_ex = 1'b0; take_ok = 1'b0;
    check("exc redirect", redirect, 1'b1);
    check("exc pc base", redirect_pc, 30'h80);
    chk_csr("exc mcause", CSR_MCAUSE, 32'h2);
    chk_csr("exc mtval", CSR_MTVAL, 32'hDEAD_BEEF);
    chk_csr("exc mepc", CSR_MEPC, {pc5, 2'b00});
    chk_csr("irq stays pending", CSR_MIP, 32'h0004_0000);
    step();
    wr(CSR_MIP, 3'b011, 32'h0004_0000);
    chk_csr("mip18 cleared", CSR_MIP, 32'h0);

    // CSR write dropped on trap cycle and during ENTER
    mret();
    check("mret exc redirect", redirect, 1'b1);
    step();
    chk_csr("MIE back on", CSR_MSTATUS, 32'h0000_1888);
    pc6 = 30'($urandom);
    t6 = $urandom;
    pc_excep = pc6;
    exc_req_ex = 1'b1; exc_cause_ex = CAUSE_ECALL_M; exc_tval_ex = t6;
    wr(CSR_MSTATUS, 3'b001, 32'h0);
    exc_req_ex = 1'b0;
    check("ecall redirect", redirect, 1'b1);
    check("ecall pc", redirect_pc, 30'h80);
    chk_csr("ecall mcause", CSR_MCAUSE, 32'd11);
    chk_csr("ecall mtval", CSR_MTVAL, t6);
    wr(CSR_MTVEC, 3'b001, 32'h0);
    chk_csr("write in ENTER dropped", CSR_MTVEC, 32'h0000_0201);
    chk_csr("write on trap dropped", CSR_MSTATUS, 32'h0000_1880);
    mret();
    check("mret ecall pc", redirect_pc, pc6);
    step();
    chk_csr("mret MIE restored", CSR_MSTATUS, 32'h0000_1888);

    // Randomized CSR op sequence against the value model
    mdl = '{32'h0000_1888, 32'h0007_0000, 32'h0000_0201, {pc6, 2'b00}, 32'd11, t6, 32'h0, 32'h0};
    for (int n = 0; n < 60; n++) begin
      int          k;
      logic [2:0]  op;
      logic [31:0] d, s;
      k  = $urandom_range(0, 7);
      op = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
      d  = $urandom;
      s  = op[2] ? {27'b0, d[4:0]} : d;
      csr_ofs_ex = raddr[k]; csr_op2_ex = op; csr_uimm_ex = d[4:0]; rs1_sel = d;
      csr_we_ex = 1'b1;
      #1;
      check("rand old value", csr_rd_data, mdl[k]);
      step();
      csr_we_ex = 1'b0;
      mdl[k] = legal(k, apply(op[1:0], mdl[k], s));
    end
    for (int k = 0; k < 8; k++) chk_csr("rand final", raddr[k], mdl[k]);
    check("rand no redirect", redirect, 1'b0);

`ifdef CSR_COUNTERS_EN
    wr(CSR_MCYCLEH, 3'b001, 32'h12);
    wr(CSR_MCYCLE, 3'b001, 32'hFFFF_FFFF);
    chk_csr("mcycle written", CSR_MCYCLE, 32'hFFFF_FFFF);
    chk_csr("mcycleh before carry", CSR_MCYCLEH, 32'h12);
    step();
    chk_csr("mcycle wrapped", CSR_MCYCLE, 32'h0);
    chk_csr("mcycleh carry", CSR_MCYCLEH, 32'h13);
    chk_csr("cycleh shadow", CSR_CYCLEH, 32'h13);
    wr(CSR_MINSTRET, 3'b001, 32'd5);
    retire_ex = 1'b1;
    step(); step(); step();
    retire_ex = 1'b0;
    chk_csr("minstret count", CSR_MINSTRET, 32'd8);
    chk_csr("instret shadow", CSR_INSTRET, 32'd8);
    chk_csr("minstreth", CSR_MINSTRETH, 32'h0);
`else
    chk_csr("no mcycle", CSR_MCYCLE, 32'h0);
    wr(CSR_MCYCLE, 3'b001, 32'd5);
    chk_csr("mcycle write ignored", CSR_MCYCLE, 32'h0);
    chk_csr("no instret", CSR_INSTRET, 32'h0);
`endif

    // Asynchronous reset while in ENTER kills the redirect
    pc7 = 30'($urandom);
    pc_excep = pc7;
    exc_req_ex = 1'b1; exc_cause_ex = CAUSE_ECALL_M;
    step();
    exc_req_ex = 1'b0;
    check("pre-reset redirect", redirect, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async rst redirect", redirect, 1'b0);
    check("async rst redirect_pc", redirect_pc, 30'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk_csr("rst2 mtvec", CSR_MTVEC, 32'h0000_0100);
    chk_csr("rst2 mstatus", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("rst2 mcause", CSR_MCAUSE, 32'h0);
    check("rst2 redirect", redirect, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
